// File: rtl/e_stage_mdu.sv
// E-stage multiply/divide unit: multi-cycle MULT/DIV into private HI/LO with a stall request.
// Optional MADD/MSUB accumulate ops are enabled by defining MDU_MADD_EN.
module e_stage_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Estart,
  input  logic [3:0]  EmdOp,
  input  logic [31:0] EsrcA,
  input  logic [31:0] EsrcB,
  input  logic        DmdInstr,
  output logic        Ebusy,
  output logic        mdStall,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] mdResult
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MSUB  = 4'd10;
`endif

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, nextState;
  logic [31:0] cnt, nextCnt;
  logic [31:0] rHi, rLo, nextRHi, nextRLo;
  logic        rWrite, nextWrite;
  logic [31:0] nextHi, nextLo;

  logic signed [63:0] sProd;
  logic        [63:0] uProd;
  logic        [31:0] divisor, sQuo, sRem, uQuo, uRem;
  logic               divOvf;

  assign sProd = $signed({{32{EsrcA[31]}}, EsrcA}) * $signed({{32{EsrcB[31]}}, EsrcB});
  assign uProd = {32'd0, EsrcA} * {32'd0, EsrcB};

  // Divisor forced to 1 on divide-by-zero; the commit is suppressed in that case anyway.
  assign divisor = (EsrcB == 32'd0) ? 32'd1 : EsrcB;
  assign divOvf  = (EsrcA == 32'h8000_0000) && (EsrcB == 32'hFFFF_FFFF);
  assign sQuo    = divOvf ? 32'h8000_0000 : $unsigned($signed(EsrcA) / $signed(divisor));
  assign sRem    = divOvf ? 32'd0         : $unsigned($signed(EsrcA) % $signed(divisor));
  assign uQuo    = EsrcA / divisor;
  assign uRem    = EsrcA % divisor;

  assign Ebusy    = (state == RUN);
  assign mdStall  = DmdInstr & (Ebusy | (Estart & (EmdOp >= OP_MULT) & (EmdOp <= OP_DIVU)));
  assign mdResult = (EmdOp == OP_MFHI) ? HI : LO;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= 32'd0;
      rHi    <= 32'd0;
      rLo    <= 32'd0;
      rWrite <= 1'b0;
      HI     <= 32'd0;
      LO     <= 32'd0;
    end else begin
      state  <= nextState;
      cnt    <= nextCnt;
      rHi    <= nextRHi;
      rLo    <= nextRLo;
      rWrite <= nextWrite;
      HI     <= nextHi;
      LO     <= nextLo;
    end
  end

  // Result is computed at start into the shadow pair and only copied to HI/LO on the last busy edge.
  always_comb begin
    nextState = state;
    nextCnt   = cnt;
    nextRHi   = rHi;
    nextRLo   = rLo;
    nextWrite = rWrite;
    nextHi    = HI;
    nextLo    = LO;
    case (state)
      IDLE: begin
        if (Estart) begin
          case (EmdOp)
            OP_MULT: begin
              {nextRHi, nextRLo} = sProd;
              nextWrite = 1'b1;
              nextCnt   = MULT_CYCLES;
              nextState = RUN;
            end
            OP_MULTU: begin
              {nextRHi, nextRLo} = uProd;
              nextWrite = 1'b1;
              nextCnt   = MULT_CYCLES;
              nextState = RUN;
            end
            OP_DIV: begin
              nextRHi   = sRem;
              nextRLo   = sQuo;
              nextWrite = (EsrcB != 32'd0);
              nextCnt   = DIV_CYCLES;
              nextState = RUN;
            end
            OP_DIVU: begin
              nextRHi   = uRem;
              nextRLo   = uQuo;
              nextWrite = (EsrcB != 32'd0);
              nextCnt   = DIV_CYCLES;
              nextState = RUN;
            end
`ifdef MDU_MADD_EN
            OP_MADD: begin
              {nextRHi, nextRLo} = {HI, LO} + sProd;
              nextWrite = 1'b1;
              nextCnt   = MULT_CYCLES;
              nextState = RUN;
            end
            OP_MSUB: begin
              {nextRHi, nextRLo} = {HI, LO} - sProd;
              nextWrite = 1'b1;
              nextCnt   = MULT_CYCLES;
              nextState = RUN;
            end
`endif
            OP_MTHI: nextHi = EsrcA;
            OP_MTLO: nextLo = EsrcA;
            default: ;
          endcase
        end
      end
      RUN: begin
        if (cnt == 32'd1) begin
          nextState = IDLE;
          nextCnt   = 32'd0;
          if (rWrite) begin
            nextHi = rHi;
            nextLo = rLo;
          end
        end else begin
          nextCnt = cnt - 32'd1;
        end
      end
      default: nextState = IDLE;
    endcase
  end

endmodule

// File: tb/tb_e_stage_mdu.sv
// Self-checking bench for e_stage_mdu: directed cases plus random ops against a 64-bit arithmetic model.
// Define MDU_MADD_EN to exercise the accumulate ops.
module tb_e_stage_mdu;

  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        Estart = 1'b0;
  logic [3:0]  EmdOp = 4'd0;
  logic [31:0] EsrcA = 32'd0;
  logic [31:0] EsrcB = 32'd0;
  logic        DmdInstr = 1'b0;
  logic        Ebusy, mdStall;
  logic [31:0] HI, LO, mdResult;

  int errors = 0;
  int checks = 0;
  logic [31:0] mHi = 32'd0;
  logic [31:0] mLo = 32'd0;
  int expCyc;
  int busyCyc;

  e_stage_mdu #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
    .clk(clk), .reset(reset), .Estart(Estart), .EmdOp(EmdOp), .EsrcA(EsrcA), .EsrcB(EsrcB),
    .DmdInstr(DmdInstr), .Ebusy(Ebusy), .mdStall(mdStall), .HI(HI), .LO(LO), .mdResult(mdResult)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Architectural model: plain 64-bit arithmetic on the operands; returns expected busy cycles.
  task automatic modelOp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int cyc);
    longint sa, sb, res;
    longint unsigned ua, ub, ures;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    cyc = 0;
    case (op)
      4'd1: begin res = sa * sb; {mHi, mLo} = res; cyc = MULT_CYCLES; end
      4'd2: begin ures = ua * ub; {mHi, mLo} = ures; cyc = MULT_CYCLES; end
      4'd3: begin
        cyc = DIV_CYCLES;
        if (b != 0) begin
          res = sa / sb; mLo = res[31:0];
          res = sa % sb; mHi = res[31:0];
        end
      end
      4'd4: begin
        cyc = DIV_CYCLES;
        if (b != 0) begin
          ures = ua / ub; mLo = ures[31:0];
          ures = ua % ub; mHi = ures[31:0];
        end
      end
      4'd7: mHi = a;
      4'd8: mLo = a;
`ifdef MDU_MADD_EN
      4'd9:  begin res = longint'({mHi, mLo}) + sa * sb; {mHi, mLo} = res; cyc = MULT_CYCLES; end
      4'd10: begin res = longint'({mHi, mLo}) - sa * sb; {mHi, mLo} = res; cyc = MULT_CYCLES; end
`endif
      default: ;
    endcase
  endtask

  // Issue one op for one cycle, then count busy cycles (bounded).
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                               output int nBusy);
    @(negedge clk);
    Estart = 1'b1; EmdOp = op; EsrcA = a; EsrcB = b;
    @(negedge clk);
    Estart = 1'b0; EmdOp = 4'd0;
    nBusy = 0;
    while (Ebusy && nBusy < 200) begin
      nBusy++;
      @(negedge clk);
    end
  endtask

  task automatic readBack(input string tag);
    EmdOp = 4'd5; #1;
    checkOutput({tag, " MFHI"}, mdResult, mHi);
    EmdOp = 4'd6; #1;
    checkOutput({tag, " MFLO"}, mdResult, mLo);
    EmdOp = 4'd0;
  endtask

  task automatic runOp(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    int exp;
    applyStimulus(op, a, b, busyCyc);
    modelOp(op, a, b, exp);
    checkOutput({tag, " busy"}, busyCyc, exp);
    checkOutput({tag, " HI"}, HI, mHi);
    checkOutput({tag, " LO"}, LO, mLo);
  endtask

  initial begin
    logic [3:0] ops [8];
    int stallBad;
    ops = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8, 4'd1, 4'd3};

    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    checkOutput("reset HI", HI, 32'd0);
    checkOutput("reset LO", LO, 32'd0);
    checkOutput("reset busy", {31'd0, Ebusy}, 32'd0);
    EmdOp = 4'd6; #1;
    checkOutput("reset MFLO", mdResult, 32'd0);

    runOp("MULT -2*3", 4'd1, 32'hFFFF_FFFE, 32'd3);
    checkOutput("MULT HI const", HI, 32'hFFFF_FFFF);
    checkOutput("MULT LO const", LO, 32'hFFFF_FFFA);
    runOp("MULTU", 4'd2, 32'hFFFF_FFFE, 32'd3);
    checkOutput("MULTU HI const", HI, 32'h0000_0002);
    runOp("DIV -7/2", 4'd3, 32'hFFFF_FFF9, 32'd2);
    checkOutput("DIV LO const", LO, 32'hFFFF_FFFD);
    checkOutput("DIV HI const", HI, 32'hFFFF_FFFF);
    runOp("DIVU by 0", 4'd4, 32'd7, 32'd0);
    runOp("DIV ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    checkOutput("DIV ovf LO const", LO, 32'h8000_0000);

    // Stall asserted through the whole MULT while the D stage holds an MDU op.
    @(negedge clk);
    DmdInstr = 1'b1; Estart = 1'b1; EmdOp = 4'd1; EsrcA = 32'd1234; EsrcB = 32'h0001_0001;
    #1;
    checkOutput("stall at issue", {31'd0, mdStall}, 32'd1);
    modelOp(4'd1, EsrcA, EsrcB, expCyc);
    @(negedge clk);
    Estart = 1'b0; EmdOp = 4'd0;
    busyCyc = 0; stallBad = 0;
    while (Ebusy && busyCyc < 200) begin
      if (mdStall !== 1'b1) stallBad++;
      busyCyc++;
      @(negedge clk);
    end
    checkOutput("stall busy cycles", stallBad, 0);
    checkOutput("stall MULT busy", busyCyc, expCyc);
    checkOutput("stall drop", {31'd0, mdStall}, 32'd0);
    DmdInstr = 1'b0;
    readBack("after stall");

    // MTHI then MFHI, with Ebusy watched each cycle.
    applyStimulus(4'd7, 32'h1234_5678, 32'd0, busyCyc);
    modelOp(4'd7, 32'h1234_5678, 32'd0, expCyc);
    checkOutput("MTHI busy", busyCyc, 0);
    readBack("MTHI");
    checkOutput("MTHI const", HI, 32'h1234_5678);

    // Reset in the middle of a DIV discards the result.
    @(negedge clk);
    Estart = 1'b1; EmdOp = 4'd3; EsrcA = 32'd100; EsrcB = 32'd7;
    @(negedge clk);
    Estart = 1'b0; EmdOp = 4'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    mHi = 32'd0; mLo = 32'd0;
    checkOutput("mid-reset busy", {31'd0, Ebusy}, 32'd0);
    checkOutput("mid-reset HI", HI, 32'd0);
    repeat (DIV_CYCLES + 2) @(negedge clk);
    checkOutput("no late commit HI", HI, 32'd0);
    checkOutput("no late commit LO", LO, 32'd0);

    // Accumulate from HI=0, LO=0xFFFFFFFF.
    runOp("MTHI 0", 4'd7, 32'd0, 32'd0);
    runOp("MTLO -1", 4'd8, 32'hFFFF_FFFF, 32'd0);
    runOp("MADD 1*1", 4'd9, 32'd1, 32'd1);
`ifdef MDU_MADD_EN
    checkOutput("MADD HI const", HI, 32'd1);
    checkOutput("MADD LO const", LO, 32'd0);
    runOp("MSUB", 4'd10, 32'hFFFF_FFF0, 32'd3);
`else
    checkOutput("MADD off HI", HI, 32'd0);
    checkOutput("MADD off LO", LO, 32'hFFFF_FFFF);
`endif

    for (int i = 0; i < 24; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if (i % 4 == 1) rb = rb >> $urandom_range(0, 31);
      runOp($sformatf("rand%0d op%0d", i, ops[i % 8]), ops[i % 8], ra, rb);
    end
    readBack("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL timeout: got no finish expected finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
